seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b0110, target sequence with MSB as the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, qualifies i; a serial bit is consumed only in cycles with en=1.
REQ-008 SHALL have port i, input, 1, serial data bit.
REQ-009 SHALL have port clr, input, 1, synchronous clear of match_cnt and sat.
REQ-010 SHALL have port y, output, 1, Mealy match flag, combinational from state, en and i.
REQ-011 SHALL have port y_q, output, 1, y registered, one cycle later.
REQ-012 SHALL have port match_cnt, output, CNT_W, number of matches since reset or clr.
REQ-013 SHALL have port sat, output, 1, sticky flag: match_cnt has reached all-ones.

Function
REQ-014 SHALL keep hist (PAT_W-1 bits, most recent bit in LSB) and fill (0..PAT_W-1, bits held valid) as the FSM state.
REQ-015 SHALL assert y when en=1, fill=PAT_W-1 and {hist,i}=PATTERN; otherwise y=0.
REQ-016 On en=1 without a match, SHALL shift i into hist and increment fill, saturating at PAT_W-1.
REQ-017 On a match with OVERLAP=1, SHALL shift i into hist and keep fill at PAT_W-1.
REQ-018 On a match with OVERLAP=0, SHALL set fill to 0; hist contents are then don't-care.
REQ-019 On en=0, SHALL hold hist, fill and match_cnt; y=0.
REQ-020 SHALL set y_q to the value of y from the previous cycle (latency 1).
REQ-021 SHALL increment match_cnt by 1 on each match, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL set sat when match_cnt reaches 2^CNT_W-1 and hold it until clr or reset.
REQ-023 When clr=1, SHALL set match_cnt to 0 and sat to 0; clr has priority over a same-cycle match, and that match is not counted. y and y_q are unaffected by clr.
REQ-024 clr SHALL NOT affect hist or fill.

Reset
REQ-025 While rst=0, SHALL immediately force hist=0, fill=0, y_q=0, match_cnt=0 and sat=0; y SHALL be 0.
REQ-026 Reset asserted mid-sequence SHALL discard partial matches; detection restarts from fill=0 after release.
REQ-027 After rst is released, the first en=1 edge SHALL consume a bit normally.

Structure
REQ-028 SHALL place no typedefs in a shared package; PAT_W, PATTERN, OVERLAP and CNT_W remain module parameters.
REQ-029 SHALL instantiate one sub-module, sat_counter (parameter W; inputs inc and clr; outputs cnt and sat), implementing REQ-021..REQ-023.
REQ-030 The implementation SHALL elaborate correctly for PAT_W=2 (1-bit hist).

Verification
REQ-031 Defaults, OVERLAP=1, stream 0,1,1,0,1,1,0 with en=1 -> y=1 on bits 4 and 7; match_cnt=2; y_q pulses one cycle after each y pulse.
REQ-032 Same stream with OVERLAP=0 -> y=1 on bit 4 only; match_cnt=1.
REQ-033 Alternating stream 1,0,1,0,... for 17 bits -> y never asserts; match_cnt=0.
REQ-034 Stream 0,1,en=0 for 3 cycles,1,0 -> state held during en=0; y=1 on the final bit; match_cnt=1.
REQ-035 CNT_W=2, five matches -> match_cnt stops at 3 with sat=1; a clr on a match cycle -> match_cnt=0 and sat=0.
REQ-036 Stream 0,1,1 then rst pulsed low asynchronously, then 0 -> no match; match_cnt=0; fill restarts at 0.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared helpers for the serial pattern detector.
// Only constant functions live here; all sizing stays on the module parameters.
package seq_detector_param_pkg;

  // Width of the fill counter, which counts 0..n-1 and is never narrower than 1 bit.
  function automatic int fill_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating match counter with a sticky "reached all-ones" flag.
// The clear input wins over a same-cycle increment, so that increment is dropped.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX    = '1;
  localparam logic [W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;

  logic [W-1:0] r_cnt;
  logic         r_sat;

  // Count increments, stop at all-ones, and latch sat on the step that reaches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_MAX_M1) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector (Mealy).
// State is the last PAT_W-1 bits seen plus how many of them are valid; the
// incoming bit completes the window, so y is combinational from state, en and i.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat
);

  localparam int             FW       = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_y_q;
  logic [PAT_W-1:0] w_window;
  logic             w_y;

  // Oldest held bit lands in the MSB, matching PATTERN's first-received-first order.
  assign w_window = {r_hist, i};

  // A match needs a full history window, a consumed bit, and the right contents.
  assign w_y = en && (r_fill == FILL_MAX) && (w_window == PATTERN);

  // Detector state: shift history on every consumed bit; after a match either keep
  // the window (overlapping) or start collecting a fresh one (non-overlapping).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y_q  <= 1'b0;
    end else begin
      r_y_q <= w_y;
      if (en) begin
        r_hist <= w_window[PAT_W-2:0];
        if (w_y && !OVERLAP) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_y),
    .clr (clr),
    .cnt (match_cnt),
    .sat (sat)
  );

  assign y   = w_y;
  assign y_q = r_y_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream; expected y values go through queues.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       clr;

  logic       y_ov, yq_ov, sat_ov;
  logic [7:0] cnt_ov;
  logic       y_no, yq_no, sat_no;
  logic [7:0] cnt_no;
  logic       y_s, yq_s, sat_s;
  logic [1:0] cnt_s;

  int total = 0;
  int bad   = 0;
  bit q_ov[$];
  bit q_no[$];
  bit prev_ov;
  bit prev_no;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .i(din), .clr(clr),
    .y(y_ov), .y_q(yq_ov), .match_cnt(cnt_ov), .sat(sat_ov)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .i(din), .clr(clr),
    .y(y_no), .y_q(yq_no), .match_cnt(cnt_no), .sat(sat_no)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .CNT_W(2)) u_s (
    .clk(clk), .rst(rst), .en(en), .i(din), .clr(clr),
    .y(y_s), .y_q(yq_s), .match_cnt(cnt_s), .sat(sat_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check Mealy y and last cycle's y_q.
  task automatic step(input bit e, input bit b, input bit c, input bit ey_ov, input bit ey_no);
    bit exp_ov;
    bit exp_no;
    @(negedge clk);
    en  = e;
    din = b;
    clr = c;
    q_ov.push_back(ey_ov);
    q_no.push_back(ey_no);
    #1;
    check("y_q_ov", yq_ov, prev_ov);
    check("y_q_no", yq_no, prev_no);
    exp_ov = q_ov.pop_front();
    exp_no = q_no.pop_front();
    check("y_ov", y_ov, exp_ov);
    check("y_no", y_no, exp_no);
    check("y_s", y_s, exp_ov);
    $display("step en=%0b i=%0b clr=%0b y_ov=%0b y_no=%0b cnt_ov=%0d cnt_no=%0d cnt_s=%0d",
             e, b, c, y_ov, y_no, cnt_ov, cnt_no, cnt_s);
    prev_ov = exp_ov;
    prev_no = exp_no;
  endtask

  // Feed n bits with en=1, MSB first, with per-bit expected y for both instances.
  task automatic run(input int n, input logic [31:0] bits, input logic [31:0] eov,
                     input logic [31:0] eno);
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b1, bits[k], 1'b0, eov[k], eno[k]);
    end
  endtask

  // Let the last driven bit be consumed, then idle and check counters.
  task automatic chk_cnt(input string tag, input int e_ov, input int e_no, input int e_s,
                         input bit e_sat_s);
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    check({tag, "_cnt_ov"}, cnt_ov, e_ov);
    check({tag, "_cnt_no"}, cnt_no, e_no);
    check({tag, "_cnt_s"}, cnt_s, e_s);
    check({tag, "_sat_s"}, sat_s, e_sat_s);
    check({tag, "_sat_ov"}, sat_ov, 1'b0);
    check({tag, "_yq_ov"}, yq_ov, prev_ov);
    $display("counts %s cnt_ov=%0d cnt_no=%0d cnt_s=%0d sat_s=%0b", tag, cnt_ov, cnt_no, cnt_s, sat_s);
  endtask

  // Pulse rst low between clock edges and check that state clears without an edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_yq_ov"}, yq_ov, 1'b0);
    check({tag, "_cnt_ov"}, cnt_ov, 0);
    check({tag, "_cnt_s"}, cnt_s, 0);
    check({tag, "_sat_s"}, sat_s, 1'b0);
    check({tag, "_y_ov"}, y_ov, 1'b0);
    check({tag, "_y_no"}, y_no, 1'b0);
    #1;
    rst = 1'b1;
    prev_ov = 1'b0;
    prev_no = 1'b0;
    $display("async reset %s", tag);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    din = 1'b0;
    clr = 1'b0;
    prev_ov = 1'b0;
    prev_no = 1'b0;

    #2;
    check("rst_yq_ov", yq_ov, 1'b0);
    check("rst_cnt_ov", cnt_ov, 0);
    check("rst_sat_s", sat_s, 1'b0);
    check("rst_y_ov", y_ov, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Stream 0110110: overlapping matches on bits 4 and 7, non-overlapping only on 4.
    run(7, 32'b0110110, 32'b0001001, 32'b0001000);
    chk_cnt("ovl", 2, 1, 2, 1'b0);

    // Alternating bits never contain 0110.
    async_reset("r1");
    run(17, 32'b10101010101010101, 32'd0, 32'd0);
    chk_cnt("alt", 0, 0, 0, 1'b0);

    // en=0 cycles hold state; the pattern completes on the final bit.
    async_reset("r2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("hold", 1, 1, 1, 1'b0);

    // Reset right after a match clears y_q and counts at once; a reset after a
    // partial 011 discards it, and detection needs a full 0110 afterwards.
    async_reset("r3");
    run(4, 32'b0110, 32'b0001, 32'b0001);
    async_reset("mid_match");
    run(3, 32'b011, 32'd0, 32'd0);
    async_reset("mid_partial");
    run(4, 32'b0110, 32'b0001, 32'b0001);
    chk_cnt("rst", 1, 1, 1, 1'b0);

    // Saturation on the 2-bit counter, then clr on a match cycle.
    async_reset("r4");
    run(7, 32'b0110110, 32'b0001001, 32'b0001000);
    chk_cnt("sat2", 2, 1, 2, 1'b0);
    run(9, 32'b110110110, 32'b001001001, 32'b001000001);
    chk_cnt("sat5", 5, 3, 3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_cnt("clr", 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
